flopen_pipe: RTL and testbench
==============================

# flopen_pipe

Parametrised elastic pipeline register: a chain of DEPTH enabled data registers, each with a valid bit, using a valid/ready handshake on both sides. It generalises the single enabled flop in width and depth. It adds backpressure, bubble collapsing, a synchronous flush and an occupancy count. It sits between processor pipeline stages and on datapath buses where a producer must be stalled without losing data.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 2, number of register stages (≥1)
- RESET_VAL, 0, value loaded into every data register on reset
- clk  input  1  rising-edge clock; the block has one clock
- reset_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous flush; invalidates all stages
- in_valid  input  1  producer has data on d
- in_ready  output  1  block accepts d this cycle
- d  input  WIDTH  input data
- out_valid  output  1  q holds valid data
- out_ready  input  1  consumer takes q this cycle
- q  output  WIDTH  output data, from stage DEPTH-1
- count  output  CNT_W  number of valid stages, 0..DEPTH; CNT_W = clog2(DEPTH+1)

## Operation
- Stage 0 is the input side. Stage DEPTH-1 drives q and out_valid directly from its registers.
- Advance rule, last stage: adv[DEPTH-1] = !v[DEPTH-1] || out_ready.
- Advance rule, stage i < DEPTH-1: adv[i] = !v[i] || adv[i+1].
- in_ready = adv[0] && !clr.
- Stage i loads on a clock edge when adv[i] = 1.
  - Stage 0 loads d and takes v[0] = in_valid && in_ready.
  - Stage i > 0 loads data[i-1] and takes v[i] = v[i-1].
- Data registers are enable-only. A stage that does not advance holds its data and valid bit.
- A stage that advances with an invalid source keeps its old data and clears its valid bit. Data under v=0 is don't-care, but it must not toggle needlessly.
- Bubbles collapse: an empty stage always loads, so valid entries pack toward the output while out_ready = 0.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - Producer and consumer must each hold their signals stable until the transfer occurs.
- count update: +1 on an input transfer only, -1 on an output transfer only, unchanged on both or neither. It is a registered counter and must always equal the popcount of v.
- clr = 1:
  - At the next edge, all v and count become 0. Data registers hold.
  - in_ready is 0 in the same cycle, so no input is accepted.
  - An output transfer in that cycle still counts as delivered to the consumer.
- Order is strictly FIFO. There is no reordering and no duplication.

## Timing
- Reset (reset_n = 0, asynchronous, valid mid-operation): all v = 0, count = 0, every data register = RESET_VAL. Outputs follow immediately: out_valid = 0, q = RESET_VAL, in_ready = 1 (when clr = 0).
- Latency: a word accepted at edge N into an empty pipe appears on q after edge N+DEPTH-1, i.e. DEPTH cycles from d to q registered.
- Throughput: one word per cycle with out_ready held at 1.
- Full pipe with out_ready = 1 and in_valid = 1: in_ready = 1. The push and pop occur together and count is unchanged.
- Full pipe with out_ready = 0: in_ready = 0.
- in_ready depends combinationally on out_ready through the adv chain, a path of DEPTH levels. This is accepted; there is no combinational path from d to q.
- clr asserted together with a full pipe and out_ready = 1: the output transfer occurs, then the pipe is empty.

## Structure
- No shared typedefs are needed. CNT_W is a localparam computed with the team's clog2 function from the common constants package.
- Natural sub-module: flopen_stage, parameter WIDTH, ports clk, reset_n, en, vin, din, vout, dout. It is an enabled data flop plus a valid flop.
- flopen_pipe instantiates DEPTH copies of flopen_stage with a generate loop, plus the adv chain and the count register.

## Test plan
All scenarios use WIDTH = 8, DEPTH = 2 unless stated.
- Reset: push 0xAA, then assert reset_n = 0 between clock edges -> immediately out_valid = 0, count = 0, q = 0x00, in_ready = 1.
- Streaming: out_ready = 1, push 0xAA, 0x24, 0x56 on consecutive cycles -> q shows 0xAA, 0x24, 0x56 on consecutive cycles, the first one 2 cycles after acceptance of 0xAA.
- Backpressure:
  - out_ready = 0, offer 0xAA, 0x24, 0x56 -> 0xAA and 0x24 accepted, count = 2, in_ready = 0 while 0x56 waits.
  - Then out_ready = 1 -> 0xAA, 0x24, 0x56 delivered in order, none lost.
- Bubble collapse: out_ready = 0, push 0xAA, one idle cycle, push 0x24 -> v = 11, q = 0xAA, count = 2.
- Simultaneous push/pop: pipe full with 0xAA, 0x24; out_ready = 1, push 0x56 -> in_ready = 1, count stays 2, next q = 0x24.
- Flush: pipe full, clr = 1 with in_valid = 1, d = 0x99 -> next cycle count = 0, out_valid = 0, and 0x99 never appears on q.

Source files
------------

// File: rtl/flopen_pipe_pkg.sv
// Shared constants and helpers for the flopen_pipe elastic pipeline register.
package flopen_pipe_pkg;

    // Bits needed to hold values 0..n-1; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/flopen_pipe_stage.sv
// One pipeline stage: an enable-only data flop paired with its valid flop.
module flopen_stage
    import flopen_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             vout,
    output logic [WIDTH-1:0] dout
);

    logic             v_q;
    logic [WIDTH-1:0] data_q;

    // Data only loads when a valid word arrives, so invalid slots never toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q    <= 1'b0;
            data_q <= RESET_VAL;
        end else if (en) begin
            v_q <= vin;
            if (vin) begin
                data_q <= din;
            end
        end
    end

    assign vout = v_q;
    assign dout = data_q;

endmodule

// File: rtl/flopen_pipe.sv
// Elastic valid/ready pipeline of DEPTH enabled stages with bubble collapsing,
// synchronous flush and a registered occupancy count.
module flopen_pipe
    import flopen_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     CNT_W     = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] stage_v;
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d   [DEPTH];

    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign in_ready = adv[0] && !clr;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == DEPTH - 1) begin : g_last
            assign adv[i] = !stage_v[i] || out_ready;
        end else begin : g_mid
            assign adv[i] = !stage_v[i] || adv[i+1];
        end

        if (i == 0) begin : g_head
            assign src_v[i] = push;
            assign src_d[i] = d;
        end else begin : g_body
            assign src_v[i] = stage_v[i-1];
            assign src_d[i] = stage_d[i-1];
        end

        // Flush forces every stage to advance with an invalid source:
        // valid bits clear while data registers keep their contents.
        flopen_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (adv[i] || clr),
            .vin     (src_v[i] && !clr),
            .din     (src_d[i]),
            .vout    (stage_v[i]),
            .dout    (stage_d[i])
        );
    end

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_valid = stage_v[DEPTH-1];
    assign q         = stage_d[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_flopen_pipe.sv
// Directed self-checking bench for flopen_pipe with WIDTH=8, DEPTH=2.
module tb_flopen_pipe;

    logic       clk;
    logic       reset_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q;
    logic [1:0] count;

    int checks;
    int failures;

    flopen_pipe #(
        .WIDTH     (8),
        .DEPTH     (2),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clr = 1'b0; in_valid = 1'b0; d = 8'h00; out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_init_valid got=%b exp=0", out_valid); end
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL rst_init_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_init_in_ready got=%b exp=1", in_ready); end
        reset_n = 1'b1;
        step();
        in_valid = 1'b1; d = 8'hAA;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || q !== 8'hAA) begin failures++; $display("FAIL rst_pre_q got=%b/%h exp=1/aa", out_valid, q); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL rst_async_count got=%0d exp=0", count); end
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL rst_async_q got=%h exp=00", q); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_in_ready got=%b exp=1", in_ready); end
        #1 reset_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid = 1'b1; d = 8'hAA;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready got=%b exp=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || count !== 2'd1) begin failures++; $display("FAIL stream_lat1 got=%b/%0d exp=0/1", out_valid, count); end
        d = 8'h24;
        step();
        checks++; if (out_valid !== 1'b1 || q !== 8'hAA) begin failures++; $display("FAIL stream_q0 got=%b/%h exp=1/aa", out_valid, q); end
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL stream_cnt2 got=%0d exp=2", count); end
        d = 8'h56;
        step();
        checks++; if (out_valid !== 1'b1 || q !== 8'h24) begin failures++; $display("FAIL stream_q1 got=%b/%h exp=1/24", out_valid, q); end
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL stream_cnt_pp got=%0d exp=2", count); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || q !== 8'h56) begin failures++; $display("FAIL stream_q2 got=%b/%h exp=1/56", out_valid, q); end
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL stream_cnt1 got=%0d exp=1", count); end
        step();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL stream_drain got=%b/%0d exp=0/0", out_valid, count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; d = 8'hAA;
        step();
        d = 8'h24;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept2 got=%b exp=1", in_ready); end
        step();
        d = 8'h56;
        #1;
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b0 || count !== 2'd2 || q !== 8'hAA) begin failures++; $display("FAIL bp_hold got=%b/%0d/%h exp=0/2/aa", in_ready, count, q); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || q !== 8'h24 || count !== 2'd2) begin failures++; $display("FAIL bp_out1 got=%b/%h/%0d exp=1/24/2", out_valid, q, count); end
        step();
        checks++; if (out_valid !== 1'b1 || q !== 8'h56 || count !== 2'd1) begin failures++; $display("FAIL bp_out2 got=%b/%h/%0d exp=1/56/1", out_valid, q, count); end
        step();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL bp_empty got=%b/%0d exp=0/0", out_valid, count); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid = 1'b1; d = 8'hAA;
        step();
        in_valid = 1'b0; d = 8'h00;
        step();
        checks++; if (out_valid !== 1'b1 || q !== 8'hAA || count !== 2'd1) begin failures++; $display("FAIL bubble_mid got=%b/%h/%0d exp=1/aa/1", out_valid, q, count); end
        in_valid = 1'b1; d = 8'h24;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || q !== 8'hAA || count !== 2'd2) begin failures++; $display("FAIL bubble_pack got=%b/%h/%0d exp=1/aa/2", out_valid, q, count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bubble_full got=%b exp=0", in_ready); end
    endtask

    task automatic test_back_to_back();
        // Pipe holds 0xAA (out) and 0x24 from test_bubble.
        out_ready = 1'b1;
        in_valid = 1'b1; d = 8'h56;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (q !== 8'h24 || count !== 2'd2) begin failures++; $display("FAIL b2b_q got=%h/%0d exp=24/2", q, count); end
        step();
        checks++; if (q !== 8'h56 || count !== 2'd1) begin failures++; $display("FAIL b2b_last got=%h/%0d exp=56/1", q, count); end
        step();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL b2b_empty got=%b/%0d exp=0/0", out_valid, count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; d = 8'h11;
        step();
        d = 8'h22;
        step();
        clr = 1'b1; d = 8'h99;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        step();
        clr = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0d/%b exp=0/0", count, out_valid); end
        checks++; if (q !== 8'h11) begin failures++; $display("FAIL flush_data_hold got=%h exp=11", q); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak cyc=%0d got=%b/%h exp=0", i, out_valid, q); end
        end
        // Full pipe, consumer ready, flush: head word transfers, then empty.
        out_ready = 1'b0;
        in_valid = 1'b1; d = 8'h33;
        step();
        d = 8'h44;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1; clr = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || q !== 8'h33) begin failures++; $display("FAIL flush_deliver got=%b/%h exp=1/33", out_valid, q); end
        step();
        clr = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_after got=%0d/%b exp=0/0", count, out_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_back_to_back();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
